// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8:1 data path.
// A winner keeps the grant for at most MAX_HOLD consecutive cycles. Every
// release, whether normal or forced, passes through at least one idle cycle.
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       dout,
  output logic       busy,
  output logic       preempt
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [2:0]      ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  win_idx;
  logic        any_req;

  // Rotate the request vector so that bit 0 is the pointer position, then pick the lowest set bit
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr_q +: 8];
    win_off = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
    // 3-bit add wraps the scan from index 7 back to 0
    win_idx = ptr_q + win_off;
    any_req = |req;
  end

  // FSM with registered grant, select, busy and preempt outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StGrant;
            gnt     <= 8'(1) << win_idx;
            sel     <= win_idx;
            cnt_q   <= CntW'(1);
            busy    <= 1'b1;
          end
        end
        StGrant: begin
          if (!req[sel] || (cnt_q == CntW'(MAX_HOLD))) begin
            state_q <= StIdle;
            gnt     <= '0;
            busy    <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= sel + 3'd1;
            // Only a holder still requesting at the limit is flagged as pre-empted
            preempt <= req[sel];
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  logic [3:0] mux_l1;
  logic [1:0] mux_l2;
  logic       mux_l3;

  // Shared data path as a three-level tree of 2:1 muxes, gated off while idle
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      mux_l1[j] = sel[0] ? din[2*j+1] : din[2*j];
    end
    for (int j = 0; j < 2; j++) begin
      mux_l2[j] = sel[1] ? mux_l1[2*j+1] : mux_l1[2*j];
    end
    mux_l3 = sel[2] ? mux_l2[1] : mux_l2[0];
    dout   = busy & mux_l3;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with MAX_HOLD = 8.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       dout;
  logic       busy;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(
    .MAX_HOLD(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .din    (din),
    .gnt    (gnt),
    .sel    (sel),
    .dout   (dout),
    .busy   (busy),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    #3;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_preempt", 8'(preempt), 8'h00);
    chk("rst_dout", 8'(dout), 8'h00);

    // Single requester 2 for three cycles
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    req   = 8'h04;
    step();
    chk("r2_gnt1", gnt, 8'h04);
    chk("r2_sel1", 8'(sel), 8'h02);
    chk("r2_busy1", 8'(busy), 8'h01);
    chk("r2_pre1", 8'(preempt), 8'h00);
    step();
    chk("r2_gnt2", gnt, 8'h04);
    chk("r2_busy2", 8'(busy), 8'h01);
    step();
    chk("r2_gnt3", gnt, 8'h04);
    chk("r2_busy3", 8'(busy), 8'h01);
    req = 8'h00;
    step();
    chk("r2_rel_gnt", gnt, 8'h00);
    chk("r2_rel_busy", 8'(busy), 8'h00);
    chk("r2_rel_sel", 8'(sel), 8'h02);
    chk("r2_rel_pre", 8'(preempt), 8'h00);
    chk("r2_ptr", 8'(dut.ptr_q), 8'h03);
    step();
    chk("idle_gnt", gnt, 8'h00);
    chk("idle_sel_hold", 8'(sel), 8'h02);

    // Wrap-around scan from ptr 3: 7, then 0, then 2
    req = 8'h85;
    step();
    chk("wrap_gnt7", gnt, 8'h80);
    chk("wrap_sel7", 8'(sel), 8'h07);
    req = 8'h05;
    step();
    chk("wrap_rel7", gnt, 8'h00);
    step();
    chk("wrap_gnt0", gnt, 8'h01);
    chk("wrap_sel0", 8'(sel), 8'h00);
    req = 8'h04;
    step();
    chk("wrap_rel0", gnt, 8'h00);
    step();
    chk("wrap_gnt2", gnt, 8'h04);
    chk("wrap_sel2", 8'(sel), 8'h02);
    req = 8'h00;
    step();
    chk("wrap_rel2", gnt, 8'h00);

    // Data path while requester 5 holds the grant
    req = 8'h20;
    step();
    chk("r5_gnt", gnt, 8'h20);
    chk("r5_sel", 8'(sel), 8'h05);
    din = 8'h20;
    #1;
    chk("r5_dout1", 8'(dout), 8'h01);
    din = 8'h00;
    #1;
    chk("r5_dout0", 8'(dout), 8'h00);
    din = 8'h10;
    req = 8'h30;
    #1;
    chk("r5_din4", 8'(dout), 8'h00);
    step();
    chk("r5_req4_gnt", gnt, 8'h20);
    chk("r5_req4_sel", 8'(sel), 8'h05);
    chk("r5_req4_dout", 8'(dout), 8'h00);
    din = 8'h20;
    #1;
    chk("r5_dout1b", 8'(dout), 8'h01);
    req = 8'h00;
    step();
    chk("r5_rel_gnt", gnt, 8'h00);
    chk("r5_idle_dout", 8'(dout), 8'h00);

    // Requester 1 held permanently: eight grant cycles, forced release, re-grant
    din = 8'h00;
    req = 8'h02;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_gnt", gnt, 8'h02);
      chk("hold_pre", 8'(preempt), 8'h00);
    end
    step();
    chk("force_gnt", gnt, 8'h00);
    chk("force_busy", 8'(busy), 8'h00);
    chk("force_pre", 8'(preempt), 8'h01);
    chk("force_ptr", 8'(dut.ptr_q), 8'h02);
    step();
    chk("regrant_gnt", gnt, 8'h02);
    chk("regrant_sel", 8'(sel), 8'h01);
    chk("regrant_pre", 8'(preempt), 8'h00);

    // Asynchronous reset mid-grant, then arbitration restarts from ptr 0
    din = 8'h02;
    #1;
    chk("pre_rst_dout", 8'(dout), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 8'h00);
    chk("arst_busy", 8'(busy), 8'h00);
    chk("arst_dout", 8'(dout), 8'h00);
    chk("arst_pre", 8'(preempt), 8'h00);
    chk("arst_sel", 8'(sel), 8'h00);
    #1;
    req   = 8'h82;
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", gnt, 8'h02);
    chk("post_rst_sel", 8'(sel), 8'h01);
    chk("post_rst_pre", 8'(preempt), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive clock cycles one requester keeps the grant; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  8  request lines; req[k] high means requester k wants the shared 8:1 path.
REQ-005 din  input  8  per-requester data bit; din[k] belongs to requester k.
REQ-006 gnt  output  8  registered one-hot grant, or all zero.
REQ-007 sel  output  3  registered select code of the granted requester, driving the 8:1 mux select.
REQ-008 dout  output  1  shared-path data out.
REQ-009 busy  output  1  registered; high while in state GRANT.
REQ-010 preempt  output  1  registered one-cycle pulse flagging a forced release.

Function
REQ-011 Two states, IDLE and GRANT; busy SHALL be high exactly when the state is GRANT.
REQ-012 Internal registers: 3-bit round-robin pointer ptr and hold counter cnt, $clog2(MAX_HOLD+1) bits wide.
REQ-013 IDLE, req == 0 at an edge: no state change; gnt stays 0; sel holds its last value.
REQ-014 IDLE, req != 0 at an edge: winner k is the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8); state -> GRANT, gnt = 1<<k, sel = k, cnt = 1.
REQ-015 Grant latency is one cycle: a request sampled in IDLE at edge N gives gnt and busy high after edge N.
REQ-016 GRANT, req[sel] low at an edge: normal release; state -> IDLE, gnt = 0, ptr = sel+1 mod 8, preempt = 0.
REQ-017 GRANT, req[sel] high and cnt == MAX_HOLD at an edge: forced release; state -> IDLE, gnt = 0, ptr = sel+1 mod 8, preempt = 1 for exactly that next cycle.
REQ-018 GRANT, req[sel] high and cnt < MAX_HOLD: state holds and cnt increments, so a holder sees at most MAX_HOLD cycles of gnt.
REQ-019 Every release passes through at least one IDLE cycle with gnt = 0; there is no grant-to-grant handoff in the same edge.
REQ-020 In GRANT, changes on req bits other than req[sel] SHALL NOT affect gnt, sel, cnt or ptr.
REQ-021 dout SHALL equal din[sel] combinationally while busy = 1, and 0 while busy = 0.
REQ-022 The 8:1 selection SHALL be built as a tree of 2:1 selections: stage 1 on sel[0], stage 2 on sel[1], stage 3 on sel[2].
REQ-023 ptr wraps from 7 to 0; the scan wraps from index 7 to 0.
REQ-024 preempt is 0 in every cycle not covered by REQ-017.
REQ-025 No output ever goes X once reset has been applied; gnt is always zero-hot or one-hot.

Reset
REQ-026 When rst_n = 0, immediately and independent of clk: state = IDLE, gnt = 0, sel = 0, busy = 0, preempt = 0, ptr = 0, cnt = 0, so dout = 0.
REQ-027 Reset asserted mid-GRANT drops the grant immediately with no preempt pulse; after release, arbitration restarts from ptr = 0.
REQ-028 Reset deassertion is synchronised by the integrator; the block takes its first decision at the first rising edge after rst_n goes high.

Verification
REQ-029 Reset, then req = 8'b0000_0100 held for 3 cycles and dropped -> gnt = 8'b0000_0100 and sel = 2 after the first edge; busy high for 3 cycles; one IDLE cycle; ptr = 3.
REQ-030 With ptr = 3, req = 8'b1000_0101 simultaneously -> requester 7 wins (sel = 7); after its release, requester 0 wins (ptr wrapped), then requester 2.
REQ-031 MAX_HOLD = 8, req[1] held high permanently -> gnt[1] high for exactly 8 cycles, then gnt = 0 with preempt = 1 for one cycle, then re-granted to requester 1 (the only requester).
REQ-032 Requester 5 granted, din = 8'b0010_0000 then 8'b0000_0000 -> dout follows as 1 then 0 in the same cycle; toggling din[4] and req[4] has no effect.
REQ-033 rst_n pulled low mid-grant between clock edges -> gnt, busy and dout go 0 without a clock edge; preempt stays 0.
REQ-034 Random req/din for 10k cycles against a reference model -> gnt is one-hot or zero in every cycle, and every continuously requesting line is granted within 8 grants.
